aes_cipher_core: RTL and testbench

Iterative AES encryption engine that sits directly downstream of the key expansion block. It consumes the flat expanded-key bus and a 128-bit plaintext block, then performs one AES round per clock. It produces the ciphertext with a one-cycle done pulse. It supports AES-128/192/256 round counts (10/12/14), selected by the same keySize encoding the key expansion block uses.

---
 rtl/aes_pkg.sv | 46 ++++
 rtl/aes_sbox.sv | 11 +
 rtl/aes_cipher_core.sv | 141 ++++++++++++++
 tb/tb_aes_cipher_core.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: S-box table, keySize encodings, round counts,
// cipher FSM states and the GF(2^8) xtime helper.
// Imported by aes_sbox and aes_cipher_core.
package aes_pkg;

    // keySize encodings shared with the key expansion block
    localparam logic [2:0] KEYSIZE_192 = 3'b010;
    localparam logic [2:0] KEYSIZE_256 = 3'b100;

    // Number of rounds per key size
    localparam logic [3:0] NR_128 = 4'd10;
    localparam logic [3:0] NR_192 = 4'd12;
    localparam logic [3:0] NR_256 = 4'd14;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Forward S-box, entry x at bits [8*x +: 8] (entry 0 leftmost)
    localparam logic [0:2047] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES S-box lookup from the package constant table.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    assign o_byte = SBOX[{i_byte, 3'b000} +: 8];

endmodule

// File: rtl/aes_cipher_core.sv
// Iterative AES encryption core: one full round per clock, fed by the flat
// expanded-key bus of the key expansion block.
// Build option: AES_MULTI_KEYSIZE_EN enables AES-192/256 via keySize; when
// undefined the core is fixed at 10 rounds and keySize is ignored.
module aes_cipher_core
    import aes_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          keyReady,
    input  logic          start,
    input  logic [2:0]    keySize,
    input  logic [0:127]  plainText,
    input  logic [0:1919] keyExp,
    output logic          busy,
    output logic          done,
    output logic [0:127]  cipherText
);

    state_t         r_fsm;
    logic [3:0]     r_round;
    logic [3:0]     r_nr;
    logic [0:127]   r_state;
    logic           r_busy;
    logic           r_done;
    logic [0:127]   r_cipher;

    logic [3:0]     w_nr_sel;
    logic           w_accept;
    logic [0:127]   w_rkey;
    logic [0:127]   w_sub;
    logic [0:127]   w_shift;
    logic [0:127]   w_mix;
    logic [0:127]   w_mid;
    logic [0:127]   w_last;

`ifdef AES_MULTI_KEYSIZE_EN
    // Round count chosen by keySize; unknown encodings fall back to AES-128
    assign w_nr_sel = (keySize == KEYSIZE_192) ? NR_192 :
                      (keySize == KEYSIZE_256) ? NR_256 : NR_128;
`else
    // keySize has no effect in the fixed AES-128 build
    logic w_unused_keysize;
    assign w_unused_keysize = ^keySize;
    assign w_nr_sel         = NR_128;
`endif

    // A new block is taken only when not mid-encryption and the key is ready
    assign w_accept = start & keyReady & (r_fsm != ROUND);

    // Round key for the round currently being computed
    assign w_rkey = keyExp[{r_round, 7'b0000000} +: 128];

    genvar gi;

    // SubBytes: sixteen parallel S-box lookups
    generate
        for (gi = 0; gi < 16; gi++) begin : g_sub
            aes_sbox u_sbox (
                .i_byte (r_state[8*gi +: 8]),
                .o_byte (w_sub[8*gi +: 8])
            );
        end
    endgenerate

    // ShiftRows: byte (row, col) takes the byte from (row, (col+row) mod 4)
    generate
        for (gi = 0; gi < 16; gi++) begin : g_shift
            localparam int ROW = gi % 4;
            localparam int COL = gi / 4;
            assign w_shift[8*gi +: 8] = w_sub[8*(ROW + 4*((COL + ROW) % 4)) +: 8];
        end
    endgenerate

    // MixColumns on each 4-byte column
    generate
        for (gi = 0; gi < 4; gi++) begin : g_mix
            logic [7:0] w_a0, w_a1, w_a2, w_a3;
            assign w_a0 = w_shift[32*gi      +: 8];
            assign w_a1 = w_shift[32*gi + 8  +: 8];
            assign w_a2 = w_shift[32*gi + 16 +: 8];
            assign w_a3 = w_shift[32*gi + 24 +: 8];
            assign w_mix[32*gi      +: 8] = xtime(w_a0) ^ xtime(w_a1) ^ w_a1 ^ w_a2 ^ w_a3;
            assign w_mix[32*gi + 8  +: 8] = w_a0 ^ xtime(w_a1) ^ xtime(w_a2) ^ w_a2 ^ w_a3;
            assign w_mix[32*gi + 16 +: 8] = w_a0 ^ w_a1 ^ xtime(w_a2) ^ xtime(w_a3) ^ w_a3;
            assign w_mix[32*gi + 24 +: 8] = xtime(w_a0) ^ w_a0 ^ w_a1 ^ w_a2 ^ xtime(w_a3);
        end
    endgenerate

    // Intermediate rounds use MixColumns, the final round skips it
    assign w_mid  = w_mix   ^ w_rkey;
    assign w_last = w_shift ^ w_rkey;

    // Cipher FSM: accept, iterate rounds, publish result with a done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm    <= IDLE;
            r_round  <= 4'd0;
            r_nr     <= NR_128;
            r_state  <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_cipher <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_fsm)
                IDLE, DONE: begin
                    if (w_accept) begin
                        r_nr    <= w_nr_sel;
                        r_state <= plainText ^ keyExp[0:127];
                        r_round <= 4'd1;
                        r_busy  <= 1'b1;
                        r_fsm   <= ROUND;
                    end else begin
                        r_fsm <= IDLE;
                    end
                end
                ROUND: begin
                    if (r_round == r_nr) begin
                        r_cipher <= w_last;
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_fsm    <= DONE;
                    end else begin
                        r_state <= w_mid;
                        r_round <= r_round + 4'd1;
                    end
                end
                default: begin
                    r_fsm  <= IDLE;
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign cipherText = r_cipher;

endmodule

// File: tb/tb_aes_cipher_core.sv
// Directed bench for aes_cipher_core using FIPS-197 vectors.
// Expanded keys are generated here from an S-box derived from GF(2^8)
// inversion plus the affine map; expected ciphertexts are FIPS constants.
// Honours AES_MULTI_KEYSIZE_EN the same way as the design.
module tb_aes_cipher_core;

    logic          clk;
    logic          rst;
    logic          keyReady;
    logic          start;
    logic [2:0]    keySize;
    logic [0:127]  plainText;
    logic [0:1919] keyExp;
    logic          busy;
    logic          done;
    logic [0:127]  cipherText;

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0]    sb [256];
    logic [0:1919] ke128, ke192, ke256, keb;

    localparam logic [0:255] KEY_C   = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [0:255] KEY_B   = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [0:127] PT_C    = 128'h00112233445566778899aabbccddeeff;
    localparam logic [0:127] PT_B    = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [0:127] CT_C1   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [0:127] CT_C2   = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [0:127] CT_C3   = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [0:127] CT_B    = 128'h3925841d02dc09fbdc118597196a0b32;

    aes_cipher_core dut (
        .clk        (clk),
        .rst        (rst),
        .keyReady   (keyReady),
        .start      (start),
        .keySize    (keySize),
        .plainText  (plainText),
        .keyExp     (keyExp),
        .busy       (busy),
        .done       (done),
        .cipherText (cipherText)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] t);
        return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
    endfunction

    function automatic logic [0:1919] expand(input logic [0:255] key, input int nk);
        logic [31:0]   w [60];
        logic [31:0]   t;
        logic [7:0]    rc;
        logic [0:1919] ke;
        int            nw;
        nw = 4 * (nk + 7);
        rc = 8'h01;
        ke = '0;
        for (int i = 0; i < nk; i++) w[i] = key[32*i +: 32];
        for (int i = nk; i < nw; i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = {t[23:0], t[31:24]};
                t  = subword(t) ^ {rc, 24'h000000};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end else if (nk == 8 && i % nk == 4) begin
                t = subword(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int i = 0; i < nw; i++) ke[32*i +: 32] = w[i];
        return ke;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One encryption: start in cycle T, done expected in cycle T+lat
    task automatic run_op(input string tag, input logic [0:127] pt, input logic [0:1919] ke,
                          input logic [2:0] ks, input int lat, input logic check_ct,
                          input logic [0:127] exp_ct, input int repulse_k, input int drop_kr_k);
        int   k;
        logic busy_ok;
        plainText = pt;
        keyExp    = ke;
        keySize   = ks;
        start     = 1'b1;
        tick();
        start   = 1'b0;
        k       = 1;
        busy_ok = 1'b1;
        while (done !== 1'b1 && k <= 40) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (k == repulse_k) start = 1'b1;
            if (k == drop_kr_k) keyReady = 1'b0;
            tick();
            start = 1'b0;
            k++;
        end
        chk({tag, " busy during rounds"}, 128'(busy_ok), 128'd1);
        chk({tag, " done latency"}, 128'(k), 128'(lat));
        chk({tag, " busy at done"}, 128'(busy), 128'd0);
        if (check_ct) chk({tag, " cipherText"}, cipherText, exp_ct);
        tick();
        chk({tag, " done single pulse"}, 128'(done), 128'd0);
        keyReady = 1'b1;
        $display("op %s: done after %0d cycles, cipherText %h", tag, k, cipherText);
    endtask

    // Expect no done pulse for n cycles
    task automatic quiet(input string tag, input int n);
        int seen;
        seen = 0;
        for (int i = 0; i < n; i++) begin
            if (done === 1'b1) seen++;
            tick();
        end
        chk(tag, 128'(seen), 128'd0);
    endtask

    initial begin
        int k;
        logic [7:0] inv;

        rst = 1'b1; keyReady = 1'b0; start = 1'b0; keySize = 3'b000;
        plainText = '0; keyExp = '0;

        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int i = 1; i < 256; i++)
                if (gmul(8'(x), 8'(i)) == 8'h01) inv = 8'(i);
            sb[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                        ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
        ke128 = expand(KEY_C, 4);
        ke192 = expand(KEY_C, 6);
        ke256 = expand(KEY_C, 8);
        keb   = expand(KEY_B, 4);

        tick(); tick();
        chk("reset busy", 128'(busy), 128'd0);
        chk("reset done", 128'(done), 128'd0);
        chk("reset cipherText", cipherText, 128'd0);
        $display("reset: busy %b done %b cipherText %h", busy, done, cipherText);
        rst = 1'b0;
        keyReady = 1'b1;
        tick();

        run_op("C1 aes128", PT_C, ke128, 3'b000, 11, 1'b1, CT_C1, 0, 0);
        run_op("AppB ks001", PT_B, keb, 3'b001, 11, 1'b1, CT_B, 0, 0);
`ifdef AES_MULTI_KEYSIZE_EN
        run_op("C2 aes192", PT_C, ke192, 3'b010, 13, 1'b1, CT_C2, 0, 0);
        run_op("C3 aes256", PT_C, ke256, 3'b100, 15, 1'b1, CT_C3, 0, 0);
`else
        run_op("C2 stim fixed128", PT_C, ke192, 3'b010, 11, 1'b0, CT_C2, 0, 0);
        run_op("C3 stim fixed128", PT_C, ke256, 3'b100, 11, 1'b0, CT_C3, 0, 0);
        run_op("C1 ks100 ignored", PT_C, ke128, 3'b100, 11, 1'b1, CT_C1, 0, 0);
`endif

        run_op("C1 restart at T+3", PT_C, ke128, 3'b000, 11, 1'b1, CT_C1, 3, 0);
        quiet("restart ignored no extra done", 15);

        keyReady = 1'b0;
        start    = 1'b1;
        tick();
        start = 1'b0;
        chk("keyReady low busy", 128'(busy), 128'd0);
        quiet("keyReady low no done", 15);
        $display("keyReady low start: busy %b", busy);
        keyReady = 1'b1;

        // Back-to-back: second start issued in the first done cycle
        plainText = PT_C; keyExp = ke128; keySize = 3'b000; start = 1'b1;
        tick();
        start = 1'b0;
        k = 1;
        while (done !== 1'b1 && k <= 40) begin tick(); k++; end
        chk("b2b first latency", 128'(k), 128'd11);
        chk("b2b first cipherText", cipherText, CT_C1);
        plainText = PT_B; keyExp = keb; start = 1'b1;
        tick();
        start = 1'b0;
        k++;
        while (done !== 1'b1 && k <= 60) begin tick(); k++; end
        chk("b2b second latency", 128'(k), 128'd22);
        chk("b2b second cipherText", cipherText, CT_B);
        $display("b2b: second done at T+%0d cipherText %h", k, cipherText);
        tick();

        // Reset mid-operation
        plainText = PT_C; keyExp = ke128; keySize = 3'b000; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i < 5; i++) tick();
        rst = 1'b1;
        tick();
        chk("midreset busy", 128'(busy), 128'd0);
        chk("midreset done", 128'(done), 128'd0);
        chk("midreset cipherText", cipherText, 128'd0);
        $display("mid reset: busy %b done %b cipherText %h", busy, done, cipherText);
        rst = 1'b0;
        tick();

        run_op("C1 after reset keyReady drop", PT_C, ke128, 3'b000, 11, 1'b1, CT_C1, 0, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
